instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the RISC-V core. It holds the program counter, issues word requests to instruction memory, and buffers returned words in a small prefetch FIFO. It presents them in order, with their PCs, to the decode stage over a valid/ready handshake. Branch/jump redirects from execute flush the buffer and discard stale in-flight responses.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC of the first fetch after reset.
- FIFO_DEPTH, 4: prefetch entries; power of two, ≥ 2.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response word valid; in request order; not back-pressurable
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  one-cycle redirect strobe from execute
- redirect_pc  in  32  redirect target
- fetch_valid  out  1  instruction available to decode
- fetch_ready  in  1  decode accepts
- fetch_instr  out  32  instruction word
- fetch_pc  out  32  PC of fetch_instr

## Operation
- Request transfer on imem_req_valid & imem_req_ready; pc += 4 on each transfer; imem_req_addr = pc.
- Credit rule: imem_req_valid = (fifo_count + outstanding < FIFO_DEPTH) & !redirect_valid. FIFO can never overflow.
- outstanding: +1 on request transfer, −1 on imem_rsp_valid; max FIFO_DEPTH.
- Each non-dropped response is pushed with its PC. A PC queue of FIFO_DEPTH entries, written at request transfer, pairs PCs with responses.
- Redirect (highest priority):
  - FIFO and PC queue emptied.
  - pc ← {redirect_pc[31:2], 2'b00}; low bits ignored.
  - drop_cnt ← outstanding − imem_rsp_valid (the same-cycle response is itself dropped).
- While drop_cnt > 0, each response decrements drop_cnt and is discarded; it is not pushed and does not count toward fifo_count.
- States: RUN (drop_cnt = 0), DRAIN (drop_cnt > 0). Requests may issue during DRAIN if credit allows. Credit counts dropped in-flight words as outstanding.

## Timing
- Reset values: pc = RESET_PC, fifo empty, outstanding = 0, drop_cnt = 0, fetch_valid = 0, imem_req_valid = 0 while reset asserted, imem_req_addr = RESET_PC.
- First request is presented in the first cycle after reset deasserts.
- Response in cycle N appears on fetch_valid in cycle N+1 (registered FIFO output).
- Sustains 1 instruction/cycle when imem_req_ready = 1, fetch_ready = 1, and memory latency ≤ FIFO_DEPTH − 1.
- fetch_valid is forced 0 in a redirect cycle; no decode handshake occurs that cycle.
- fetch_instr/fetch_pc are stable while fetch_valid & !fetch_ready, unless redirect.
- Simultaneous push and pop on a full FIFO is legal. Push on empty with pop is not a bypass: data appears next cycle.
- imem_req_valid may drop without a handshake only in a redirect cycle.
- Reset asserted mid-operation returns everything to reset values immediately. Memory responses after reset release are the system's responsibility; memory is reset together with fetch.

## Configuration
- FETCH_PERF_CNT_EN defined: adds output ports perf_fetched (32, decode handshakes) and perf_stall (32, cycles with fetch_ready & !fetch_valid). Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package fetch_pkg: XLEN = 32, INSTR_BYTES = 4, RESET_PC default, NOP constant 32'h0000_0013, fetch_state_t {RUN, DRAIN}.
- Sub-module fetch_fifo: parameterised synchronous FIFO (data + pc), with flush, count, full, and empty. Instantiated once.

## Test plan
- Reset, then release with imem_req_ready = 1 -> first imem_req_addr = 0x0000_0000; fetch_valid = 0 until the first response.
- 1-cycle memory, fetch_ready = 1 -> fetch_pc sequence 0x0, 0x4, 0x8, …, one per cycle, with data matching memory.
- fetch_ready = 0 for 10 cycles -> exactly 4 requests issued, then imem_req_valid = 0. Releasing fetch_ready drains 4 in order and requests resume.
- 3-cycle memory, redirect to 0x100 with 2 in flight -> both stale words dropped; next fetch_pc = 0x100 with the word from 0x100.
- redirect_pc = 0x0000_0103 -> next request address 0x0000_0100.
- Assert reset mid-stream with 3 FIFO entries -> fetch_valid = 0 immediately, then restart at RESET_PC; perf counters (FETCH_PERF_CNT_EN) read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   XLEN             - datapath / address width
//   INSTR_BYTES      - bytes per instruction word (pc increment)
//   RESET_PC_DEFAULT - default PC of the first fetch after reset
//   NOP              - canonical RV32I nop (addi x0, x0, 0)
//   fetch_state_t    - RUN / DRAIN control states
//   word_align()     - clears the byte-offset bits of an address
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO holding (instruction, pc) pairs.
// The head entry is read straight from the storage registers, so a word
// pushed in cycle N becomes visible at the head in cycle N+1 (no bypass).
// Ports:
//   clock, reset        - rising-edge clock, async active-high reset
//   flush               - empties the FIFO (wins over push/pop)
//   push, push_data/pc  - write one entry
//   pop                 - retire the head entry
//   head_data/head_pc   - head entry contents
//   count, full, empty  - occupancy status
import fetch_pkg::*;

module fetch_fifo #(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  input  logic [XLEN-1:0] push_pc,
  input  logic            pop,
  output logic [XLEN-1:0] head_data,
  output logic [XLEN-1:0] head_pc,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty
);

  logic [XLEN-1:0] data_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // A push into a full FIFO is only accepted when the head leaves the same
  // cycle; the slot being written is then the one being read out.
  assign do_push = push & (!full | pop) & !flush;
  assign do_pop  = pop & !empty & !flush;

  assign head_data = data_mem[rd_ptr_q];
  assign head_pc   = pc_mem[rd_ptr_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      data_mem[wr_ptr_q] <= push_data;
      pc_mem[wr_ptr_q]   <= push_pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RISC-V instruction fetch stage.
// Holds the PC, issues word requests to instruction memory under a credit
// scheme that can never overflow the prefetch FIFO, pairs returned words
// with their PCs and hands them to decode over valid/ready. A redirect from
// execute flushes everything buffered and discards in-flight responses.
// Ports:
//   clock, reset                       - rising-edge clock, async active-high reset
//   imem_req_valid/ready, imem_req_addr - fetch request channel
//   imem_rsp_valid, imem_rsp_data       - in-order response channel, no back-pressure
//   redirect_valid, redirect_pc         - one-cycle redirect from execute
//   fetch_valid/ready, fetch_instr/pc   - decode handshake
// Optional build macro FETCH_PERF_CNT_EN adds:
//   perf_fetched - count of decode handshakes
//   perf_stall   - count of cycles with fetch_ready & !fetch_valid
//
// state | meaning
// RUN   | no stale responses pending, every response is kept
// DRAIN | drop_cnt > 0, next responses belong to pre-redirect requests
import fetch_pkg::*;

module instr_fetch_unit #(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_instr,
  output logic [XLEN-1:0] fetch_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  fetch_state_t    state_q;

  logic [XLEN-1:0] pcq_mem [FIFO_DEPTH];
  logic [AW-1:0]   pcq_wr_q, pcq_rd_q;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full_unused;
  logic            fifo_empty;
  logic [XLEN-1:0] head_data, head_pc;

  logic [CW:0]     in_use;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_keep;
  logic            fetch_fire;

  // Credit covers both buffered words and every word still in flight,
  // including stale ones that will be dropped.
  assign in_use    = (CW+1)'(fifo_count) + (CW+1)'(outstanding_q);
  assign credit_ok = (in_use < (CW+1)'(FIFO_DEPTH));

  assign imem_req_valid = credit_ok & !redirect_valid & !reset;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_keep = imem_rsp_valid & (state_q == RUN) & !redirect_valid;

  assign fetch_valid = !fifo_empty & !redirect_valid;
  assign fetch_fire  = fetch_valid & fetch_ready;
  assign fetch_instr = fifo_empty ? NOP : head_data;
  assign fetch_pc    = head_pc;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)  pc_d = word_align(redirect_pc);
    else if (req_fire)   pc_d = pc_q + XLEN'(INSTR_BYTES);
  end

  // req_fire is never set in a redirect cycle, so one formula covers both.
  assign outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

  // A response arriving in the redirect cycle is already stale, hence it is
  // subtracted from what still has to be dropped.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid)
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
    else if (imem_rsp_valid && state_q == DRAIN)
      drop_cnt_d = drop_cnt_q - CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      state_q       <= RUN;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      state_q       <= (drop_cnt_d != '0) ? DRAIN : RUN;
    end
  end

  // PC queue: one entry per live (non-stale) request, consumed by the
  // matching kept response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcq_wr_q <= '0;
      pcq_rd_q <= '0;
    end else if (redirect_valid) begin
      pcq_wr_q <= '0;
      pcq_rd_q <= '0;
    end else begin
      if (req_fire) pcq_wr_q <= pcq_wr_q + AW'(1);
      if (rsp_keep) pcq_rd_q <= pcq_rd_q + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (req_fire) pcq_mem[pcq_wr_q] <= pc_q;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (imem_rsp_data),
    .push_pc   (pcq_mem[pcq_rd_q]),
    .pop       (fetch_fire),
    .head_data (head_data),
    .head_pc   (head_pc),
    .count     (fifo_count),
    .full      (fifo_full_unused),
    .empty     (fifo_empty)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(fetch_fire);
      perf_stall   <= perf_stall + 32'(fetch_ready & !fetch_valid);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  instr_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clock = ~clock;

  // Memory model: word at address A is ~A, returned lat cycles after the request.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc;
  int    lat;
  int    fires;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in the settled part of a cycle: records this cycle's request,
  // moves to the next cycle and drives the memory response for it.
  task automatic tick();
    #1;
    if (!reset && imem_req_valid && imem_req_ready) begin
      mq.push_back('{imem_req_addr, cyc + lat});
      fires++;
    end
    @(negedge clock);
    cyc++;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~mq[0].addr;
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    mq.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    #1;
    tick();
    reset = 1'b0;
    cyc   = 0;
    fires = 0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] p;
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fetch_ready    = 1'b1;
    lat            = 1;
    cyc            = 0;
    fires          = 0;

    // Reset state
    @(negedge clock); #1;
    chk("rst_req_valid",   32'(imem_req_valid), 32'd0);
    chk("rst_req_addr",    imem_req_addr,       32'h0);
    chk("rst_fetch_valid", 32'(fetch_valid),    32'd0);
    tick();

    // Release, 1-cycle memory, fetch_ready=1: one instruction per cycle
    reset = 1'b0; cyc = 0; fires = 0; #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr",  imem_req_addr,       32'h0);
    chk("c0_fetch_valid",  32'(fetch_valid),    32'd0);
    tick();
    chk("c1_fetch_valid",  32'(fetch_valid),    32'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      p = 32'(4 * k);
      chk("stream_valid",     32'(fetch_valid),    32'd1);
      chk("stream_pc",        fetch_pc,            p);
      chk("stream_instr",     fetch_instr,         ~p);
      chk("stream_req_valid", 32'(imem_req_valid), 32'd1);
      tick();
    end

    // fetch_ready held low: exactly FIFO_DEPTH requests, then stop
    fetch_ready = 1'b0;
    apply_reset();
    repeat (5) tick();
    chk("stall_c5_valid", 32'(fetch_valid), 32'd1);
    chk("stall_c5_pc",    fetch_pc,         32'h0);
    repeat (4) tick();
    chk("stall_fires",     32'(fires),          32'd4);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_c9_pc",     fetch_pc,            32'h0);
    chk("stall_c9_instr",  fetch_instr,         ~32'h0);
    fetch_ready = 1'b1; #1;
    chk("drain_c10_pc",    fetch_pc,            32'h0);
    chk("drain_c10_req",   32'(imem_req_valid), 32'd0);
    tick();
    chk("drain_c11_pc",    fetch_pc,            32'h4);
    chk("drain_c11_req",   32'(imem_req_valid), 32'd1);
    chk("drain_c11_addr",  imem_req_addr,       32'h10);
    tick();
    chk("drain_c12_pc",    fetch_pc,            32'h8);
    tick();
    chk("drain_c13_pc",    fetch_pc,            32'hC);
    tick();
    chk("drain_c14_pc",    fetch_pc,            32'h10);
    chk("drain_c14_instr", fetch_instr,         ~32'h10);

    // 3-cycle memory, redirect to 0x100 with two requests in flight
    lat = 3;
    apply_reset();
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; #1;
    chk("redir_req_valid",   32'(imem_req_valid), 32'd0);
    chk("redir_fetch_valid", 32'(fetch_valid),    32'd0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("redir_next_addr",   imem_req_addr,       32'h100);
    chk("redir_next_valid",  32'(imem_req_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("redir_stale_drop", 32'(fetch_valid), 32'd0);
    end
    tick();
    chk("redir_c7_valid", 32'(fetch_valid), 32'd1);
    chk("redir_c7_pc",    fetch_pc,         32'h100);
    chk("redir_c7_instr", fetch_instr,      ~32'h100);
    tick();
    chk("redir_c8_pc",    fetch_pc,         32'h104);
    tick();

    // Unaligned redirect target while FIFO holds a word
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
    chk("redir2_kill_valid", 32'(fetch_valid), 32'd0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("redir2_addr",      imem_req_addr,       32'h100);
    chk("redir2_req_valid", 32'(imem_req_valid), 32'd1);
    for (int k = 0; k < 20 && !fetch_valid; k++) tick();
    chk("redir2_found", 32'(fetch_valid), 32'd1);
    chk("redir2_cycle", 32'(cyc),         32'd14);
    chk("redir2_pc",    fetch_pc,         32'h100);
    chk("redir2_instr", fetch_instr,      ~32'h100);

    // Reset mid-stream with three FIFO entries
    lat = 1;
    fetch_ready = 1'b0;
    apply_reset();
    repeat (4) tick();
    chk("pre_rst_valid", 32'(fetch_valid), 32'd1);
    reset = 1'b1;
    mq.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    #1;
    chk("mid_rst_fetch_valid", 32'(fetch_valid),    32'd0);
    chk("mid_rst_req_valid",   32'(imem_req_valid), 32'd0);
    chk("mid_rst_req_addr",    imem_req_addr,       32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("mid_rst_perf_fetched", perf_fetched, 32'd0);
    chk("mid_rst_perf_stall",   perf_stall,   32'd0);
`endif
    tick();
    reset = 1'b0; cyc = 0; fires = 0; fetch_ready = 1'b1; #1;
    chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
    chk("restart_req_addr",  imem_req_addr,       32'h0);
    tick();
    tick();
    chk("restart_valid", 32'(fetch_valid), 32'd1);
    chk("restart_pc",    fetch_pc,         32'h0);
    chk("restart_instr", fetch_instr,      ~32'h0);
    tick();
    chk("restart_pc2",   fetch_pc,         32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
